// File: rtl/mircore_pkg.sv
// Shared definitions for the BIOS-side instruction path: the HALT opcode and
// the boot-loader state encoding. A NOP is the all-zeros word.
package mircore_pkg;

  localparam int         OPCODE_W    = 6;
  localparam logic [5:0] HALT_OPCODE = 6'b011101;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_LOAD = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } loader_state_e;

  // States in which the loader is willing to take a stream word
  function automatic logic state_accepts(input loader_state_e s);
    return (s == S_LEN) || (s == S_LOAD) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/bios_boot_loader.sv
// BIOS boot loader: receives a length-prefixed program image on a valid/ready
// word stream, writes it into instruction memory starting at BASE_ADDR and
// feeds NOPs to the BIOS/memory mux until the image is in, then a HALT that
// hands fetch over to memory.
// Optional feature macro: BOOT_CHECKSUM_EN (adds a trailing checksum word).
//
// Handshake: a word transfers on a posedge where in_valid && in_ready are both
// high; in_ready is registered and never depends combinationally on in_valid;
// the producer must hold in_data stable while in_valid is high and not ready.
module bios_boot_loader
  import mircore_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] bios_instr,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [2:0]            dbg_state
);

  localparam logic [DATA_WIDTH-1:0] HALT_WORD  = {HALT_OPCODE, {(DATA_WIDTH-OPCODE_W){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] BASE_A     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
`ifdef BOOT_CHECKSUM_EN
  localparam loader_state_e         LOAD_EXIT  = S_CSUM;
`else
  localparam loader_state_e         LOAD_EXIT  = S_DONE;
`endif

  loader_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] idx_q, idx_d;
  logic                  in_ready_q;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] bios_q;
  logic                  done_q;
  logic                  err_q;
  logic                  ovf_d;
  logic [ADDR_WIDTH:0]   wc_q;
  logic                  xfer;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  assign xfer = in_valid && in_ready_q;

  // Next-state and write-request decode
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_LEN: begin
        if (xfer) begin
          len_d = in_data;
          idx_d = '0;
`ifdef BOOT_CHECKSUM_EN
          sum_d = '0;
`endif
          state_d = (in_data == '0) ? LOAD_EXIT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          idx_d = idx_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          // Words past the end of memory are swallowed and flagged
          if ((idx_q >> ADDR_WIDTH) == '0) begin
            we_d    = 1'b1;
            addr_d  = BASE_A + idx_q[ADDR_WIDTH-1:0];
            wdata_d = in_data;
          end else begin
            ovf_d = 1'b1;
          end
          if (idx_q + 1'b1 == len_q) state_d = LOAD_EXIT;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
  end

  // State and registered outputs; HALT trails the final write by one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LEN;
      len_q      <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= BASE_A;
      wdata_q    <= '0;
      bios_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wc_q       <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      in_ready_q <= state_accepts(state_d);
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bios_q     <= (state_q == S_DONE) ? HALT_WORD : '0;
      done_q     <= (state_q == S_DONE);
      err_q      <= err_q | ovf_d | (state_d == S_ERR);
      if (we_d && (wc_q != DEPTH_CNT)) wc_q <= wc_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign bios_instr = bios_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = wc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bios_boot_loader.sv
// Bench for bios_boot_loader: a default-size instance and a 4-word instance
// share one stream driver; write monitors pop expected {addr,data} pairs.
module tb_bios_boot_loader;
  import mircore_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int SAW = 2;
  localparam logic [DW-1:0] HALT = 32'h7400_0000;
  localparam logic [DW-1:0] NOP  = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;

  logic          in_ready, mem_we, load_done, load_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, bios_instr;
  logic [AW:0]   word_count;
  logic [2:0]    dbg_state;

  logic           s_in_ready, s_mem_we, s_load_done, s_load_err;
  logic [SAW-1:0] s_mem_addr;
  logic [DW-1:0]  s_mem_wdata, s_bios_instr;
  logic [SAW:0]   s_word_count;
  logic [2:0]     s_dbg_state;

  bios_boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .bios_instr(bios_instr),
    .load_done(load_done), .load_err(load_err), .word_count(word_count), .dbg_state(dbg_state)
  );

  bios_boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(SAW), .BASE_ADDR(0)) u_small (
    .clk(clk), .rst(s_rst), .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .bios_instr(s_bios_instr),
    .load_done(s_load_done), .load_err(s_load_err), .word_count(s_word_count), .dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0]  exp_q[$];
  logic [SAW+DW-1:0] exp_s_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  bit sel    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL main_unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else check("main_write", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
    if (s_mem_we === 1'b1) begin
      if (exp_s_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL small_unexpected_write: addr 0x%0h data 0x%0h, expected no write", s_mem_addr, s_mem_wdata);
      end else check("small_write", {s_mem_addr, s_mem_wdata}, exp_s_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] d);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (((sel ? s_in_ready : in_ready) !== 1'b1) && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("send_ready", sel ? s_in_ready : in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic send_csum(input logic [DW-1:0] s);
`ifdef BOOT_CHECKSUM_EN
    send(s);
`else
    in_data = s;
`endif
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_main_reset(input string tag);
    check({tag, "_in_ready"},   in_ready,   1'b0);
    check({tag, "_mem_we"},     mem_we,     1'b0);
    check({tag, "_mem_addr"},   mem_addr,   0);
    check({tag, "_mem_wdata"},  mem_wdata,  0);
    check({tag, "_bios_instr"}, bios_instr, NOP);
    check({tag, "_load_done"},  load_done,  1'b0);
    check({tag, "_load_err"},   load_err,   1'b0);
    check({tag, "_word_count"}, word_count, 0);
    check({tag, "_state"},      dbg_state,  S_LEN);
  endtask

  task automatic do_reset(input bit use_small);
    idle();
    sel   = use_small;
    rst   = 1'b0;
    s_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = !use_small;
    s_rst = use_small;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    // 1: reset values, then N=3 image with continuous valid
    idle();
    rst = 1'b0; s_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_main_reset("t1_reset");
    rst = 1'b1;
    send(3);
    exp_q.push_back({10'd0, 32'hA});
    exp_q.push_back({10'd1, 32'hB});
    exp_q.push_back({10'd2, 32'hC});
    send(32'hA); send(32'hB); send(32'hC);
    send_csum(32'h21);
    idle();
    check("t1_ready_dropped", in_ready, 1'b0);
    check("t1_nop_with_last_write", bios_instr, NOP);
    @(posedge clk); #1;
    check("t1_halt", bios_instr, HALT);
    check("t1_done", load_done, 1'b1);
    check("t1_count", word_count, 3);
    check("t1_err", load_err, 1'b0);
    check("t1_state", dbg_state, S_DONE);

    // 2: empty image
    do_reset(1'b0);
    send(0);
    send_csum(0);
    idle();
    check("t2_nop_first", bios_instr, NOP);
    @(posedge clk); #1;
    check("t2_halt", bios_instr, HALT);
    check("t2_done", load_done, 1'b1);
    check("t2_count", word_count, 0);

    // 3: N=4 with a 5-cycle valid gap between words 2 and 3
    do_reset(1'b0);
    send(4);
    exp_q.push_back({10'd0, 32'h11});
    exp_q.push_back({10'd1, 32'h22});
    exp_q.push_back({10'd2, 32'h33});
    exp_q.push_back({10'd3, 32'h44});
    send(32'h11); send(32'h22);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_gap_nop", bios_instr, NOP);
      check("t3_gap_addr_hold", mem_addr, 1);
      if (i > 0) check("t3_gap_no_write", mem_we, 1'b0);
      @(posedge clk); #1;
    end
    send(32'h33); send(32'h44);
    send_csum(32'hAA);
    idle();
    check("t3_nop_before_done", bios_instr, NOP);
    @(posedge clk); #1;
    check("t3_halt", bios_instr, HALT);
    check("t3_count", word_count, 4);

    // 4: 4-word memory, N=6 overflows but still completes
    do_reset(1'b1);
    send(6);
    for (int k = 1; k <= 4; k++) exp_s_q.push_back({2'(k - 1), 32'(k)});
    for (int k = 1; k <= 6; k++) begin
      send(32'(k));
      if (k == 4) check("t4_err_before_ovf", s_load_err, 1'b0);
      if (k == 5) check("t4_err_on_ovf", s_load_err, 1'b1);
    end
    send_csum(32'd21);
    idle();
    @(posedge clk); #1;
    check("t4_halt", s_bios_instr, HALT);
    check("t4_done", s_load_done, 1'b1);
    check("t4_count", s_word_count, 4);
    check("t4_err_sticky", s_load_err, 1'b1);

`ifdef BOOT_CHECKSUM_EN
    // 5: checksum good, then bad
    do_reset(1'b0);
    send(2);
    exp_q.push_back({10'd0, 32'h5});
    exp_q.push_back({10'd1, 32'h7});
    send(32'h5); send(32'h7); send(32'hC);
    idle();
    @(posedge clk); #1;
    check("t5_good_halt", bios_instr, HALT);
    check("t5_good_err", load_err, 1'b0);
    do_reset(1'b0);
    send(2);
    exp_q.push_back({10'd0, 32'h5});
    exp_q.push_back({10'd1, 32'h7});
    send(32'h5); send(32'h7); send(32'hD);
    idle();
    check("t5_bad_ready", in_ready, 1'b0);
    check("t5_bad_err", load_err, 1'b1);
    @(posedge clk); #1;
    check("t5_bad_nop", bios_instr, NOP);
    check("t5_bad_done", load_done, 1'b0);
    check("t5_bad_state", dbg_state, S_ERR);
`endif

    // 6: reset mid-load, then a fresh N=1 load
    do_reset(1'b0);
    send(5);
    exp_q.push_back({10'd0, 32'h31});
    exp_q.push_back({10'd1, 32'h32});
    send(32'h31); send(32'h32);
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    check_main_reset("t6_abort");
    rst = 1'b1;
    send(1);
    exp_q.push_back({10'd0, 32'h77});
    send(32'h77);
    send_csum(32'h77);
    idle();
    @(posedge clk); #1;
    check("t6_halt", bios_instr, HALT);
    check("t6_count", word_count, 1);
    check("t6_addr", mem_addr, 0);

    repeat (2) @(posedge clk);
    check("main_queue_empty", exp_q.size(), 0);
    check("small_queue_empty", exp_s_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
